// File: rtl/midi_route_sched_if.sv
// midi_route_sched_if
// Bundles the signals between the scheduler and the midi_port array.
// master: the scheduler. It reads the receive FIFO flags and data and the
//         transmitter ready flags, and it drives the read strobes and the
//         per-destination transmit bus.
// slave : the port array (or a testbench standing in for it).
// Signals (PORTS ports, byte lanes of 8 bits, port-number lanes of 4 bits):
//   rx_empty  [PORTS]      receive FIFO empty flags
//   rx_rden   [PORTS]      one-hot FIFO read strobe
//   rxdata    [PORTS*8]    FIFO read data, port p at [p*8+:8]
//   tx_ready  [PORTS]      transmitter can accept a byte
//   txdv      [PORTS]      per-destination data-valid pulse
//   txdata    [PORTS*8]    byte per destination
//   txcurport [PORTS*4]    source port number per destination
interface midi_route_sched_if #(
  parameter int PORTS = 4
);
  logic [PORTS-1:0]   rx_empty;
  logic [PORTS-1:0]   rx_rden;
  logic [PORTS*8-1:0] rxdata;
  logic [PORTS-1:0]   tx_ready;
  logic [PORTS-1:0]   txdv;
  logic [PORTS*8-1:0] txdata;
  logic [PORTS*4-1:0] txcurport;

  modport master (
    input  rx_empty, rxdata, tx_ready,
    output rx_rden, txdv, txdata, txcurport
  );

  modport slave (
    output rx_empty, rxdata, tx_ready,
    input  rx_rden, txdv, txdata, txcurport
  );
endinterface

// File: rtl/midi_route_sched.sv
// midi_route_sched
// Round-robin scheduler moving received MIDI bytes from the per-port receive
// FIFOs to the transmitters of the other ports. One byte is in flight at a
// time: it is popped, latched together with its destination mask, held until
// every destination is ready, then presented to all destinations at once.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   bus        midi_route_sched_if.master (FIFO side and transmit side)
//   route_map  destination mask per source, source s at [s*PORTS+:PORTS]
//   busy       1 whenever the scheduler is not scanning
//   drop_cnt   saturating count of bytes that had no destination
module midi_route_sched #(
  parameter int PORTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  midi_route_sched_if.master     bus,
  input  logic [PORTS*PORTS-1:0] route_map,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  typedef enum logic [2:0] {SCAN, READ, LATCH, WAIT, SEND} state_t;

  state_t             state;
  state_t             next_state;
  logic [3:0]         ptr;
  logic [3:0]         src;
  logic [3:0]         src_next;
  logic [3:0]         scan_port;
  logic               scan_found;
  int                 scan_dist;
  int                 scan_best;
  logic [PORTS-1:0]   src_onehot;
  logic [PORTS-1:0]   live_mask;
  logic [PORTS-1:0]   send_mask;
  logic [PORTS-1:0]   mask_q;
  logic [7:0]         live_byte;
  logic [7:0]         send_byte;
  logic [7:0]         data_q;
  logic               all_ready;
  logic [PORTS-1:0]   rden;
  logic [PORTS-1:0]   dv;
  logic [PORTS*8-1:0] txdata_q;
  logic [PORTS*4-1:0] txcurport_q;

  // Pick the non-empty port closest to ptr going upwards with wrap-around.
  // Measuring the wrapped distance per port avoids a variable-index search.
  always_comb begin
    scan_port = '0;
    scan_best = PORTS;
    scan_dist = 0;
    for (int p = 0; p < PORTS; p++) begin
      if (!bus.rx_empty[p]) begin
        scan_dist = p - int'(ptr);
        if (scan_dist < 0) scan_dist = scan_dist + PORTS;
        if (scan_dist < scan_best) begin
          scan_best = scan_dist;
          scan_port = 4'(p);
        end
      end
    end
  end

  assign scan_found = |(~bus.rx_empty);

  // Decode the current source into its strobe, its FIFO data lane and its
  // route entry; the source never routes back to itself.
  always_comb begin
    src_onehot = '0;
    live_byte  = '0;
    live_mask  = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (src == 4'(p)) begin
        src_onehot[p] = 1'b1;
        live_byte     = bus.rxdata[p*8 +: 8];
        live_mask     = route_map[p*PORTS +: PORTS];
      end
    end
    live_mask = live_mask & ~src_onehot;
  end

  assign src_next = (src == 4'(PORTS-1)) ? 4'd0 : src + 4'd1;

  // In LATCH the byte and mask come straight from the FIFO and route map so
  // a fully ready destination set skips WAIT; afterwards the latched copy is
  // used so route_map changes cannot touch the byte in flight.
  assign send_mask = (state == LATCH) ? live_mask : mask_q;
  assign send_byte = (state == LATCH) ? live_byte : data_q;
  assign all_ready = (bus.tx_ready & send_mask) == send_mask;

  // Next-state and strobe outputs.
  always_comb begin
    next_state = state;
    rden       = '0;
    dv         = '0;
    busy       = 1'b1;
    case (state)
      SCAN: begin
        busy = 1'b0;
        if (scan_found) next_state = READ;
      end
      READ: begin
        rden       = src_onehot;
        next_state = LATCH;
      end
      LATCH: begin
        if (live_mask == '0)  next_state = SCAN;
        else if (all_ready)   next_state = SEND;
        else                  next_state = WAIT;
      end
      WAIT: begin
        if (all_ready) next_state = SEND;
      end
      SEND: begin
        dv         = mask_q;
        next_state = SCAN;
      end
      default: next_state = SCAN;
    endcase
  end

  // State, pointer, latched byte and held transmit lanes. The transmit lanes
  // load on the edge entering SEND so they are valid alongside txdv.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= SCAN;
      ptr         <= '0;
      src         <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      drop_cnt    <= '0;
      txdata_q    <= '0;
      txcurport_q <= '0;
    end else begin
      state <= next_state;
      case (state)
        SCAN: begin
          if (scan_found) src <= scan_port;
        end
        LATCH: begin
          data_q <= live_byte;
          mask_q <= live_mask;
          if (live_mask == '0) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            ptr <= src_next;
          end
        end
        SEND: begin
          ptr <= src_next;
        end
        default: ;
      endcase
      if (next_state == SEND) begin
        for (int p = 0; p < PORTS; p++) begin
          if (send_mask[p]) begin
            txdata_q[p*8 +: 8]    <= send_byte;
            txcurport_q[p*4 +: 4] <= src;
          end
        end
      end
    end
  end

  assign bus.rx_rden   = rden;
  assign bus.txdv      = dv;
  assign bus.txdata    = txdata_q;
  assign bus.txcurport = txcurport_q;

endmodule

// File: tb/tb_midi_route_sched.sv
// tb_midi_route_sched
// Directed and randomized bench for midi_route_sched with PORTS=4. The bench
// plays the port array: it holds per-port FIFO contents, pops on rx_rden and
// presents the popped byte on rxdata. Expected traffic comes from a
// transaction-level model of the round-robin routing rules.
module tb_midi_route_sched;
  localparam int PORTS = 4;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [31:0]        cyc;
    logic [PORTS-1:0]   dv;
    logic [PORTS*8-1:0] data;
    logic [PORTS*4-1:0] cur;
  } send_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [PORTS*PORTS-1:0] route_map;
  logic                   busy;
  logic [7:0]             drop_cnt;

  midi_route_sched_if #(.PORTS(PORTS)) bus ();

  midi_route_sched #(.PORTS(PORTS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .route_map(route_map),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int               tests_run = 0;
  int               tests_failed = 0;
  int               protocol_errs = 0;
  int               cycle = 0;
  bit               rand_ready = 1'b0;
  logic [7:0]       mem [PORTS][DEPTH];
  int               head [PORTS];
  int               tail [PORTS];
  send_t            sends [$];
  logic [PORTS-1:0] rdens [$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    tests_run++;
    tests_failed++;
    $error("[TB] FAIL %s: observed no event within budget, expected event", tag);
  endtask

  // Push one byte into a port FIFO.
  task automatic applyStimulus(input int port, input logic [7:0] b);
    mem[port][tail[port]] = b;
    tail[port]++;
    bus.rx_empty[port] = 1'b0;
  endtask

  // Advance to the next falling edge, log DUT activity, service FIFO pops.
  task automatic tick();
    send_t s;
    @(negedge clk);
    cycle++;
    if (bus.txdv !== '0) begin
      s.cyc  = cycle;
      s.dv   = bus.txdv;
      s.data = bus.txdata;
      s.cur  = bus.txcurport;
      sends.push_back(s);
    end
    if (bus.rx_rden !== '0) begin
      rdens.push_back(bus.rx_rden);
      if ($countones(bus.rx_rden) != 1) protocol_errs++;
      if ((bus.rx_rden & bus.txdv) != '0) protocol_errs++;
      for (int p = 0; p < PORTS; p++) begin
        if (bus.rx_rden[p]) begin
          if (head[p] < tail[p]) begin
            bus.rxdata[p*8 +: 8] = mem[p][head[p]];
            head[p]++;
          end else begin
            protocol_errs++;
          end
        end
      end
    end
    for (int p = 0; p < PORTS; p++) bus.rx_empty[p] = (head[p] == tail[p]);
    if (rand_ready) begin
      for (int p = 0; p < PORTS; p++) bus.tx_ready[p] = ($urandom_range(0, 3) != 0);
    end
  endtask

  function automatic bit fifosEmpty();
    for (int p = 0; p < PORTS; p++) if (head[p] != tail[p]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic waitIdle(input int budget, input string tag);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = fifosEmpty() && (busy === 1'b0);
    end
    if (!done) timeoutFail(tag);
  endtask

  task automatic waitRden(input string tag);
    int n0 = rdens.size();
    int n = 0;
    while (rdens.size() == n0 && n < 50) begin
      tick();
      n++;
    end
    if (rdens.size() == n0) timeoutFail(tag);
  endtask

  task automatic waitSends(input int count, input string tag);
    int n = 0;
    while (sends.size() < count && n < 100) begin
      tick();
      n++;
    end
    if (sends.size() < count) timeoutFail(tag);
  endtask

  task automatic doReset();
    rst          = 1'b0;
    rand_ready   = 1'b0;
    bus.tx_ready = '1;
    route_map    = '1;
    bus.rxdata   = '0;
    bus.rx_empty = '1;
    for (int p = 0; p < PORTS; p++) begin
      head[p] = 0;
      tail[p] = 0;
    end
    tick();
    tick();
    rst = 1'b1;
    sends.delete();
    rdens.delete();
  endtask

  // Random FIFO contents and route map; the model replays the routing rules
  // over the queued bytes to predict every send and the drop count.
  task automatic runRandomRound(input int round);
    send_t            exp_q [$];
    send_t            e;
    int               mh [PORTS];
    int               ptr;
    int               s;
    int               drops;
    logic [PORTS-1:0] m;
    logic [7:0]       b;
    logic [PORTS*8-1:0] hd;
    logic [PORTS*4-1:0] hc;
    string            tag;

    doReset();
    route_map = (PORTS*PORTS)'($urandom);
    for (int p = 0; p < PORTS; p++) begin
      int n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) applyStimulus(p, 8'($urandom));
    end

    for (int p = 0; p < PORTS; p++) mh[p] = head[p];
    ptr = 0; drops = 0; hd = '0; hc = '0;
    while (1) begin
      s = -1;
      for (int k = 0; k < PORTS; k++) begin
        int q = (ptr + k) % PORTS;
        if (s < 0 && mh[q] < tail[q]) s = q;
      end
      if (s < 0) break;
      b = mem[s][mh[s]];
      mh[s]++;
      m = route_map[s*PORTS +: PORTS];
      m[s] = 1'b0;
      if (m == '0) begin
        if (drops < 255) drops++;
      end else begin
        for (int d = 0; d < PORTS; d++) begin
          if (m[d]) begin
            hd[d*8 +: 8] = b;
            hc[d*4 +: 4] = 4'(s);
          end
        end
        e.cyc = '0; e.dv = m; e.data = hd; e.cur = hc;
        exp_q.push_back(e);
      end
      ptr = (s + 1) % PORTS;
    end

    rand_ready = 1'b1;
    waitIdle(3000, $sformatf("rand%0d_idle", round));
    rand_ready   = 1'b0;
    bus.tx_ready = '1;

    checkOutput($sformatf("rand%0d_count", round), 64'(sends.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sends.size(); i++) begin
      tag = $sformatf("rand%0d_send%0d", round, i);
      checkOutput({tag, "_dv"}, 64'(sends[i].dv), 64'(exp_q[i].dv));
      checkOutput({tag, "_data"}, 64'(sends[i].data), 64'(exp_q[i].data));
      checkOutput({tag, "_cur"}, 64'(sends[i].cur), 64'(exp_q[i].cur));
    end
    checkOutput($sformatf("rand%0d_drops", round), 64'(drop_cnt), 64'(drops));
  endtask

  initial begin
    logic any_dv;
    logic all_busy;
    int   n;

    // Reset values
    rst          = 1'b0;
    route_map    = '1;
    bus.tx_ready = '1;
    bus.rxdata   = '0;
    bus.rx_empty = '1;
    for (int p = 0; p < PORTS; p++) begin
      head[p] = 0;
      tail[p] = 0;
    end
    tick();
    checkOutput("reset_rden", 64'(bus.rx_rden), 64'h0);
    checkOutput("reset_txdv", 64'(bus.txdv), 64'h0);
    checkOutput("reset_txdata", 64'(bus.txdata), 64'h0);
    checkOutput("reset_txcurport", 64'(bus.txcurport), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    checkOutput("reset_drop", 64'(drop_cnt), 64'h0);
    doReset();

    // Single byte from port 1 to all other ports
    applyStimulus(1, 8'h90);
    waitRden("single_rden_wait");
    checkOutput("single_rden", 64'(bus.rx_rden), 64'b0010);
    tick();
    checkOutput("single_gap_txdv", 64'(bus.txdv), 64'h0);
    tick();
    checkOutput("single_txdv", 64'(bus.txdv), 64'b1101);
    checkOutput("single_txdata", 64'(bus.txdata), 64'h90900090);
    checkOutput("single_txcurport", 64'(bus.txcurport), 64'h1101);
    tick();
    checkOutput("single_pulse_end", 64'(bus.txdv), 64'h0);
    checkOutput("single_hold", 64'(bus.txdata), 64'h90900090);

    // Round-robin order with a late arrival on port 0
    doReset();
    applyStimulus(0, 8'hA0);
    applyStimulus(2, 8'hA2);
    applyStimulus(3, 8'hA3);
    waitSends(1, "rr_first_send");
    applyStimulus(0, 8'hB0);
    waitIdle(100, "rr_idle");
    checkOutput("rr_count", 64'(sends.size()), 64'd4);
    if (sends.size() == 4) begin
      checkOutput("rr_s0_dv", 64'(sends[0].dv), 64'b1110);
      checkOutput("rr_s0_data", 64'(sends[0].data), 64'hA0A0A000);
      checkOutput("rr_s1_data", 64'(sends[1].data), 64'hA2A0A2A2);
      checkOutput("rr_s1_cur", 64'(sends[1].cur), 64'h2022);
      checkOutput("rr_s2_data", 64'(sends[2].data), 64'hA2A3A3A3);
      checkOutput("rr_s2_cur", 64'(sends[2].cur), 64'h2333);
      checkOutput("rr_s3_data", 64'(sends[3].data), 64'hB0B0B0A3);
      checkOutput("rr_s3_cur", 64'(sends[3].cur), 64'h0003);
      checkOutput("rr_gap01", 64'(sends[1].cyc - sends[0].cyc), 64'd4);
      checkOutput("rr_gap12", 64'(sends[2].cyc - sends[1].cyc), 64'd4);
      checkOutput("rr_gap23", 64'(sends[3].cyc - sends[2].cyc), 64'd4);
    end

    // Backpressure on destination 3
    doReset();
    bus.tx_ready = 4'b0111;
    applyStimulus(0, 8'h55);
    waitRden("bp_rden_wait");
    any_dv   = 1'b0;
    all_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_dv   = any_dv | (|bus.txdv);
      all_busy = all_busy & busy;
    end
    checkOutput("bp_no_txdv", 64'(any_dv), 64'h0);
    checkOutput("bp_busy", 64'(all_busy), 64'h1);
    bus.tx_ready = 4'b1111;
    tick();
    checkOutput("bp_txdv", 64'(bus.txdv), 64'b1110);
    checkOutput("bp_txdata", 64'(bus.txdata), 64'h55555500);
    tick();
    checkOutput("bp_pulse_end", 64'(bus.txdv), 64'h0);

    // Masking and drop
    doReset();
    route_map = 16'hF4FF;
    applyStimulus(2, 8'h01);
    applyStimulus(2, 8'h02);
    applyStimulus(2, 8'h03);
    waitIdle(100, "drop_idle");
    checkOutput("drop_no_send", 64'(sends.size()), 64'd0);
    checkOutput("drop_cnt3", 64'(drop_cnt), 64'd3);
    route_map = 16'hF1FF;
    applyStimulus(2, 8'h77);
    waitIdle(100, "mask_idle");
    checkOutput("mask_count", 64'(sends.size()), 64'd1);
    if (sends.size() == 1) begin
      checkOutput("mask_dv", 64'(sends[0].dv), 64'b0001);
      checkOutput("mask_data", 64'(sends[0].data), 64'h00000077);
      checkOutput("mask_cur", 64'(sends[0].cur), 64'h0002);
    end

    // Saturation of the drop counter
    doReset();
    route_map = 16'hF4FF;
    for (int i = 0; i < 260; i++) applyStimulus(2, 8'(i));
    waitIdle(1200, "sat_idle");
    checkOutput("sat_drop", 64'(drop_cnt), 64'd255);
    checkOutput("sat_no_send", 64'(sends.size()), 64'd0);

    // Reset while waiting for a destination
    doReset();
    applyStimulus(1, 8'h11);
    waitIdle(100, "rst_pre_idle");
    bus.tx_ready = 4'b0111;
    applyStimulus(2, 8'h66);
    waitRden("rst_rden_wait");
    checkOutput("rst_pop_p2", 64'(bus.rx_rden), 64'b0100);
    tick();
    tick();
    checkOutput("rst_wait_busy", 64'(busy), 64'h1);
    checkOutput("rst_wait_txdv", 64'(bus.txdv), 64'h0);
    applyStimulus(3, 8'h33);
    applyStimulus(0, 8'h44);
    n = sends.size();
    rst = 1'b0;
    bus.tx_ready = 4'b1111;
    tick();
    checkOutput("rst_mid_rden", 64'(bus.rx_rden), 64'h0);
    checkOutput("rst_mid_txdv", 64'(bus.txdv), 64'h0);
    checkOutput("rst_mid_txdata", 64'(bus.txdata), 64'h0);
    checkOutput("rst_mid_txcurport", 64'(bus.txcurport), 64'h0);
    checkOutput("rst_mid_busy", 64'(busy), 64'h0);
    checkOutput("rst_mid_drop", 64'(drop_cnt), 64'h0);
    rst = 1'b1;
    waitRden("rst_after_rden");
    checkOutput("rst_first_port0", 64'(bus.rx_rden), 64'b0001);
    waitIdle(100, "rst_post_idle");
    checkOutput("rst_post_count", 64'(sends.size()), 64'(n + 2));
    if (sends.size() == n + 2) begin
      checkOutput("rst_post_s0", 64'(sends[n].data), 64'h44444400);
      checkOutput("rst_post_s1", 64'(sends[n+1].data), 64'h44333333);
    end

    // Randomized traffic against the routing model
    for (int r = 0; r < 4; r++) runRandomRound(r);

    checkOutput("protocol", 64'(protocol_errs), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
